instr_mem_loader: RTL and testbench



---
 rtl/instr_mem_loader_pkg.sv | 27 ++
 rtl/instr_mem_loader_encoder.sv | 39 +++
 rtl/instr_mem_loader.sv | 109 ++++++++++
 tb/tb_instr_mem_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction loader and immediate generator:
// opcode classes, instruction field positions and loader state encoding.
package instr_mem_loader_pkg;

  localparam logic [1:0] OPC_I  = 2'b00;
  localparam logic [1:0] OPC_R  = 2'b01;
  localparam logic [1:0] OPC_S  = 2'b10;
  localparam logic [1:0] OPC_SB = 2'b11;

  localparam int unsigned OPCODE_LSB   = 0;
  localparam int unsigned RD_LSB       = 7;
  localparam int unsigned FUNCT3_LSB   = 12;
  localparam int unsigned RS1_LSB      = 15;
  localparam int unsigned RS2_LSB      = 20;
  localparam int unsigned FUNCT7_LSB   = 25;
  localparam int unsigned IMM_I_LSB    = 20;
  localparam int unsigned IMM_S_HI_LSB = 25;
  localparam int unsigned IMM_S_LO_LSB = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FULL = 2'd3
  } state_t;

endpackage

// File: rtl/instr_mem_loader_encoder.sv
// Combinational field-to-word packer; opcode[6:5] selects the I/R/S layout.
module instr_encoder
  import instr_mem_loader_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    word[OPCODE_LSB +: 7] = opcode;
    word[FUNCT3_LSB +: 3] = funct3;
    word[RS1_LSB +: 5]    = rs1;
    case (opcode[6:5])
      OPC_I: begin
        word[RD_LSB +: 5]     = rd;
        word[IMM_I_LSB +: 12] = imm;
      end
      OPC_R: begin
        word[RD_LSB +: 5]     = rd;
        word[RS2_LSB +: 5]    = rs2;
        word[FUNCT7_LSB +: 7] = funct7;
      end
      default: begin
        // S and SB share a layout; rd is not encoded
        word[RS2_LSB +: 5]      = rs2;
        word[IMM_S_HI_LSB +: 7] = imm[11:5];
        word[IMM_S_LO_LSB +: 5] = imm[4:0];
      end
    endcase
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Accepts field bundles via valid/ready, encodes them and writes them
// sequentially into IMEM with one cycle of latency.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] BASE_C  = BASE_ADDR[ADDR_W-1:0];

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W:0]     accepts;
  logic [ADDR_W-1:0]   ptr;
  logic [31:0]         enc_word;
  logic                accept;
  logic                restart;

  assign accept   = in_valid && in_ready;
  assign restart  = start && (state != RUN);
  assign mem_addr = ptr;

  instr_encoder u_encoder (
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .word   (enc_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (accept) begin
          if (in_last)                           state_nxt = DONE;
          else if ((accepts + 1'b1) == DEPTH_C)  state_nxt = FULL;
        end
      end
      DONE, FULL: if (start) state_nxt = RUN;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN) && (accepts < DEPTH_C);
    done     = (state == DONE);
    overflow = (state == FULL);
  end

  // Write stage runs regardless of state so the last accepted word still
  // lands in the first DONE/FULL cycle; a restart overrides the advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepts   <= '0;
      ptr       <= BASE_C;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_wdata <= enc_word;
        accepts   <= accepts + 1'b1;
      end
      if (restart) begin
        accepts <= '0;
        ptr     <= BASE_C;
        count   <= '0;
      end else if (mem_we) begin
        ptr   <= ptr + 1'b1;
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: small DEPTH and a non-zero base so
// the address wrap and the overflow path are both reachable.
module tb_instr_mem_loader;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int BASE   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [11:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              overflow;

  instr_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] word;
    bit          done_e;
    bit          ovf_e;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model: session flag, accepted-word count and end flags.
  bit m_run  = 0;
  bit m_done = 0;
  bit m_ovf  = 0;
  int m_acc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [11:0] imm);
    logic [31:0] w;
    w = 32'(op) + (32'(f3) << 12) + (32'(rs1) << 15);
    case (op[6:5])
      2'b00:   w = w + (32'(rd) << 7) + (32'(imm) << 20);
      2'b01:   w = w + (32'(rd) << 7) + (32'(rs2) << 20) + (32'(f7) << 25);
      default: w = w + (32'(rs2) << 20) + ((32'(imm) / 32) << 25) + ((32'(imm) % 32) << 7);
    endcase
    return w;
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mem_addr",  32'(mem_addr), 32'(e.addr));
        chk("mem_wdata", mem_wdata, e.word);
        chk("done_at_write", 32'(done), 32'(e.done_e));
        chk("ovf_at_write",  32'(overflow), 32'(e.ovf_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    if (!m_run) begin
      m_run = 1; m_acc = 0; m_done = 0; m_ovf = 0;
    end
    #1 start = 1'b0;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [11:0] imm, input logic last, input logic [31:0] w);
    bit   rdy;
    exp_t e;
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    rdy = m_run && (m_acc < DEPTH);
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk);
    if (rdy) begin
      e.addr = (BASE + m_acc) % (1 << ADDR_W);
      e.word = w;
      m_acc++;
      if (last) begin
        m_run = 0; m_done = 1;
      end else if (m_acc == DEPTH) begin
        m_run = 0; m_ovf = 1;
      end
      e.done_e = m_done;
      e.ovf_e  = m_ovf;
      sb.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic last);
    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    op = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    f3 = 3'($urandom); f7 = 7'($urandom); imm = 12'($urandom);
    send(op, rd, rs1, rs2, f3, f7, imm, last, ref_encode(op, rd, rs1, rs2, f3, f7, imm));
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, "_done"},     32'(done),     32'(m_done));
    chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, "_count"},    32'(count),    32'(m_acc));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(m_run && (m_acc < DEPTH)));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mem_we",   32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 32'(BASE));
    chk("rst_wdata",    mem_wdata, 0);
    chk("rst_count",    32'(count), 0);
    chk("rst_flags",    32'({done, overflow}), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_state("idle");

    // Single I-type with last
    do_start();
    send(7'b0000011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 12'h005, 1'b1, 32'h0051_0083);
    idle(2);
    check_state("itype");

    // Back-to-back R, S, I; addresses wrap past the top of IMEM
    do_start();
    send(7'b0110011, 5'd4, 5'd2, 5'd3, 3'd0, 7'b0100000, 12'hABC, 1'b0, 32'h4031_0233);
    send(7'b1000011, 5'd9, 5'd1, 5'd5, 3'd2, 7'd0, 12'h7FF, 1'b0, 32'h7E50_AFC3);
    send(7'b0000011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 12'h005, 1'b1, 32'h0051_0083);
    idle(2);
    check_state("b2b");

    // Overflow: DEPTH+1 bundles, none last
    do_start();
    for (int i = 0; i < DEPTH + 1; i++) send_rand(1'b0);
    idle(2);
    check_state("full");
    do_start();
    check_state("restart");

    // Reset with the third write pending
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_mem_we",   32'(mem_we), 0);
    chk("midrst_count",    32'(count), 0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'(BASE));
    chk("midrst_in_ready", 32'(in_ready), 0);
    sb.delete();
    m_run = 0; m_acc = 0; m_done = 0; m_ovf = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check_state("post_rst");
    do_start();
    send_rand(1'b1);
    idle(2);
    check_state("post_rst_load");

    // Randomized sessions
    repeat (30) begin
      int n;
      do_start();
      n = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        if (m_run && $urandom_range(0, 7) == 0) do_start();
        send_rand((i == n - 1) && ($urandom_range(0, 1) == 1));
      end
      idle(2);
      check_state("rand");
    end

    idle(3);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
